// File: rtl/ddot_arbiter.sv
// ddot_arbiter: two-requester round-robin front end for one basic_ddot unit.
// Issues at most one operand set per cycle. An in-order tag FIFO remembers
// which requester owns each in-flight operation so results are routed back
// to their owner, independent of the unit latency.
module ddot_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_vld,
    input  logic [127:0] req0_x,
    input  logic [127:0] req0_y,
    output logic         req0_rdy,
    input  logic         req1_vld,
    input  logic [127:0] req1_x,
    input  logic [127:0] req1_y,
    output logic         req1_rdy,
    output logic         rsp0_vld,
    output logic [31:0]  rsp0_z,
    output logic         rsp1_vld,
    output logic [31:0]  rsp1_z,
    output logic         dd_ready,
    output logic [127:0] dd_x,
    output logic [127:0] dd_y,
    input  logic         dd_vld,
    input  logic [31:0]  dd_z,
    output logic         busy,
    output logic         err
);
    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic             last;       // most recently granted requester
    logic [PW:0]      count;
    logic [PW:0]      count_nxt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] tag_mem;    // owner of each in-flight op, 1 = requester 1

    logic sel0, sel1, room;
    logic acc0, acc1, push, pop, spurious, head_tag;

    // Round-robin select; a tie goes to the requester not granted last.
    // The full check uses the pre-pop count, so a same-cycle pop frees
    // nothing until the next cycle.
    always_comb begin
        sel0      = req0_vld & (~req1_vld | last);
        sel1      = req1_vld & (~req0_vld | ~last);
        room      = (count < FULL);
        req0_rdy  = ~rst & sel0 & room;
        req1_rdy  = ~rst & sel1 & room;
        acc0      = req0_vld & req0_rdy;
        acc1      = req1_vld & req1_rdy;
        push      = acc0 | acc1;
        pop       = dd_vld & (count != '0);
        spurious  = dd_vld & (count == '0);
        head_tag  = tag_mem[rd_ptr];
        count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
    end

    // Issue register: the granted operands go to the unit for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dd_ready <= 1'b0;
            dd_x     <= '0;
            dd_y     <= '0;
            last     <= 1'b1;
        end else begin
            dd_ready <= push;
            dd_x     <= acc1 ? req1_x : (acc0 ? req0_x : '0);
            dd_y     <= acc1 ? req1_y : (acc0 ? req0_y : '0);
            if (push)
                last <= acc1;
        end
    end

    // Tag FIFO: push owner on accept, pop head on each result from the unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= acc1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            busy  <= (count_nxt != '0);
        end
    end

    // Return path: steer the result to the head owner; the other port's z holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
            rsp0_z   <= '0;
            rsp1_z   <= '0;
        end else begin
            rsp0_vld <= pop & ~head_tag;
            rsp1_vld <= pop & head_tag;
            if (pop & ~head_tag)
                rsp0_z <= dd_z;
            if (pop & head_tag)
                rsp1_z <= dd_z;
        end
    end

    // Sticky error: a result arrived with nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (spurious)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_ddot_arbiter.sv
// Bench for ddot_arbiter: two instances (DEPTH=8/L=3 and DEPTH=2/L=6) share
// one stimulus stream; each drives its own stub dot-product unit. A queue
// model of in-flight operations predicts every output on every cycle.
module tb_ddot_arbiter;
    localparam int D0 = 8, L0 = 3, D1 = 2, L1 = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         req0_vld, req1_vld, spur;
    logic [127:0] req0_x, req0_y, req1_x, req1_y;
    logic         rdy0 [2], rdy1 [2], rsp0_vld [2], rsp1_vld [2];
    logic [31:0]  rsp0_z [2], rsp1_z [2];
    logic         dd_ready [2], dd_vld [2], busy [2], err [2];
    logic [127:0] dd_x [2], dd_y [2];
    logic [31:0]  dd_z [2];

    ddot_arbiter #(.DEPTH(D0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_x(req0_x), .req0_y(req0_y), .req0_rdy(rdy0[0]),
        .req1_vld(req1_vld), .req1_x(req1_x), .req1_y(req1_y), .req1_rdy(rdy1[0]),
        .rsp0_vld(rsp0_vld[0]), .rsp0_z(rsp0_z[0]), .rsp1_vld(rsp1_vld[0]), .rsp1_z(rsp1_z[0]),
        .dd_ready(dd_ready[0]), .dd_x(dd_x[0]), .dd_y(dd_y[0]), .dd_vld(dd_vld[0]), .dd_z(dd_z[0]),
        .busy(busy[0]), .err(err[0])
    );

    ddot_arbiter #(.DEPTH(D1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_x(req0_x), .req0_y(req0_y), .req0_rdy(rdy0[1]),
        .req1_vld(req1_vld), .req1_x(req1_x), .req1_y(req1_y), .req1_rdy(rdy1[1]),
        .rsp0_vld(rsp0_vld[1]), .rsp0_z(rsp0_z[1]), .rsp1_vld(rsp1_vld[1]), .rsp1_z(rsp1_z[1]),
        .dd_ready(dd_ready[1]), .dd_x(dd_x[1]), .dd_y(dd_y[1]), .dd_vld(dd_vld[1]), .dd_z(dd_z[1]),
        .busy(busy[1]), .err(err[1])
    );

    // FP32 <-> real for normal numbers and zero (all stimulus values are exact).
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] dot(input logic [127:0] x, input logic [127:0] y);
        real s = 0.0;
        for (int i = 0; i < 4; i++)
            s = s + f2r(x[32*i +: 32]) * f2r(y[32*i +: 32]);
        return r2f(s);
    endfunction

    function automatic logic [127:0] rep4(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [127:0] rnd_vec();
        logic [127:0] v;
        for (int i = 0; i < 4; i++)
            v[32*i +: 32] = r2f(real'($urandom_range(0, 7)));
        return v;
    endfunction

    // Stub units: dd_vld follows the dd_ready cycle by exactly L cycles.
    logic        pv [2][8];
    logic [31:0] pz [2][8];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 8; i++) begin
                    pv[d][i] <= 1'b0;
                    pz[d][i] <= 32'd0;
                end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 7; i > 0; i--) begin
                    pv[d][i] <= pv[d][i-1];
                    pz[d][i] <= pz[d][i-1];
                end
                pv[d][0] <= dd_ready[d];
                pz[d][0] <= dot(dd_x[d], dd_y[d]);
            end
        end
    end
    assign dd_vld[0] = pv[0][L0-1] | spur;
    assign dd_vld[1] = pv[1][L1-1] | spur;
    assign dd_z[0]   = spur ? 32'hdeadbeef : pz[0][L0-1];
    assign dd_z[1]   = spur ? 32'hdeadbeef : pz[1][L1-1];

    // Model state
    typedef struct {
        int          inst;
        bit          owner;
        logic [31:0] z;
    } op_t;
    op_t          inflight [$];
    bit           m_last [2], m_ddr [2], m_busy [2], m_err [2];
    bit           m_rv [2][2];
    logic [31:0]  m_rz [2][2];
    logic [127:0] m_ddx [2], m_ddy [2];

    int checks = 0, errors = 0, cyc = 0, phase = 0;
    int acc_cyc = 0, ph4_acc = 0, grant_n = 0;
    bit ph4_done = 0, tie_done = 0;

    function automatic int dep(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    task automatic chk(input int d, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %h expected %h (cycle %0d)", d, name, act, exp, cyc);
        end
    endtask

    task automatic step(input int d);
        int cnt, idx;
        bit s0, s1, e0, e1, a0, a1, t;
        if (rst) begin
            chk(d, "rst_rdy0", rdy0[d], 0);
            chk(d, "rst_rdy1", rdy1[d], 0);
            chk(d, "rst_rsp0_vld", rsp0_vld[d], 0);
            chk(d, "rst_rsp1_vld", rsp1_vld[d], 0);
            chk(d, "rst_rsp0_z", rsp0_z[d], 0);
            chk(d, "rst_rsp1_z", rsp1_z[d], 0);
            chk(d, "rst_dd_ready", dd_ready[d], 0);
            chk(d, "rst_dd_x", dd_x[d], 0);
            chk(d, "rst_dd_y", dd_y[d], 0);
            chk(d, "rst_busy", busy[d], 0);
            chk(d, "rst_err", err[d], 0);
            m_last[d] = 1; m_ddr[d] = 0; m_busy[d] = 0; m_err[d] = 0;
            m_ddx[d] = '0; m_ddy[d] = '0;
            for (int p = 0; p < 2; p++) begin
                m_rv[d][p] = 0;
                m_rz[d][p] = '0;
            end
            for (int i = inflight.size() - 1; i >= 0; i--)
                if (inflight[i].inst == d) inflight.delete(i);
            return;
        end

        cnt = 0;
        foreach (inflight[i]) if (inflight[i].inst == d) cnt++;
        s0 = req0_vld && (!req1_vld || m_last[d]);
        s1 = req1_vld && (!req0_vld || !m_last[d]);
        e0 = s0 && (cnt < dep(d));
        e1 = s1 && (cnt < dep(d));

        chk(d, "rdy0", rdy0[d], e0);
        chk(d, "rdy1", rdy1[d], e1);
        chk(d, "dd_ready", dd_ready[d], m_ddr[d]);
        chk(d, "dd_x", dd_x[d], m_ddx[d]);
        chk(d, "dd_y", dd_y[d], m_ddy[d]);
        chk(d, "rsp0_vld", rsp0_vld[d], m_rv[d][0]);
        chk(d, "rsp1_vld", rsp1_vld[d], m_rv[d][1]);
        chk(d, "rsp0_z", rsp0_z[d], m_rz[d][0]);
        chk(d, "rsp1_z", rsp1_z[d], m_rz[d][1]);
        chk(d, "busy", busy[d], m_busy[d]);
        chk(d, "err", err[d], m_err[d]);

        // Hand-computed expectations for the directed phases
        if (d == 0 && phase == 1) begin
            if (req0_vld && rdy0[0]) acc_cyc = cyc;
            if (rsp0_vld[0]) begin
                chk(d, "ph1_z", rsp0_z[0], 32'h40800000);
                chk(d, "ph1_latency", cyc - acc_cyc, L0 + 2);
            end
        end
        if (d == 0 && phase == 3 && rsp1_vld[0])
            chk(d, "ph3_z", rsp1_z[0], 32'h41000000);
        if (d == 0 && phase == 2) begin
            if ((req0_vld && rdy0[0]) || (req1_vld && rdy1[0])) begin
                chk(d, "ph2_grant", rdy1[0], grant_n % 2);
                grant_n++;
            end
            if (rsp0_vld[0]) chk(d, "ph2_z0", rsp0_z[0], 32'h40800000);
            if (rsp1_vld[0]) chk(d, "ph2_z1", rsp1_z[0], 32'h41800000);
        end
        if (d == 1 && phase == 4 && !ph4_done) begin
            if (dd_vld[1]) begin
                chk(d, "ph4_accepts_before_first_result", ph4_acc, 2);
                ph4_done = 1;
            end
            if (req0_vld && rdy0[1]) ph4_acc++;
        end
        if (d == 0 && phase == 8 && !tie_done && req0_vld && req1_vld) begin
            chk(d, "post_rst_tie_rdy0", rdy0[0], 1);
            chk(d, "post_rst_tie_rdy1", rdy1[0], 0);
            tie_done = 1;
        end

        // Advance the model across the coming edge
        m_rv[d][0] = 0;
        m_rv[d][1] = 0;
        if (dd_vld[d]) begin
            if (cnt > 0) begin
                idx = -1;
                foreach (inflight[i]) if (idx < 0 && inflight[i].inst == d) idx = i;
                t = inflight[idx].owner;
                m_rv[d][t] = 1;
                m_rz[d][t] = inflight[idx].z;
                inflight.delete(idx);
                cnt--;
            end else begin
                m_err[d] = 1;
            end
        end
        a0 = req0_vld && e0;
        a1 = req1_vld && e1;
        if (a0 || a1) begin
            m_ddr[d]  = 1;
            m_ddx[d]  = a1 ? req1_x : req0_x;
            m_ddy[d]  = a1 ? req1_y : req0_y;
            m_last[d] = a1;
            inflight.push_back('{inst: d, owner: a1, z: dot(m_ddx[d], m_ddy[d])});
            cnt++;
        end else begin
            m_ddr[d] = 0;
            m_ddx[d] = '0;
            m_ddy[d] = '0;
        end
        m_busy[d] = (cnt != 0);
    endtask

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) step(d);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; spur = 0;
        req0_vld = 0; req1_vld = 0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        tick(3);
        rst = 0;
        tick(2);

        // single op on requester 0
        phase = 1;
        req0_x = rep4(32'h3f800000); req0_y = rep4(32'h3f800000); req0_vld = 1;
        tick(1);
        req0_vld = 0;
        tick(12);

        // partial zero operand on requester 1
        phase = 3;
        req1_x = rep4(32'h40000000); req1_y = {32'd0, 32'd0, 32'h40000000, 32'h40000000};
        req1_vld = 1;
        tick(1);
        req1_vld = 0;
        tick(15);

        // both requesters held valid for 4 cycles
        phase = 2;
        req0_x = rep4(32'h3f800000); req0_y = rep4(32'h3f800000);
        req1_x = rep4(32'h40000000); req1_y = rep4(32'h40000000);
        req0_vld = 1; req1_vld = 1;
        tick(4);
        req0_vld = 0; req1_vld = 0;
        tick(20);

        // continuous requester 0 against the shallow FIFO
        phase = 4;
        req0_vld = 1;
        tick(24);
        req0_vld = 0;
        tick(15);

        // randomized traffic
        phase = 7;
        for (int i = 0; i < 500; i++) begin
            req0_vld = ($urandom_range(0, 3) != 0);
            req1_vld = ($urandom_range(0, 2) != 0);
            req0_x = rnd_vec(); req0_y = rnd_vec();
            req1_x = rnd_vec(); req1_y = rnd_vec();
            tick(1);
        end
        req0_vld = 0; req1_vld = 0;
        tick(20);

        // spurious result with nothing in flight, then reset clears err
        phase = 5;
        spur = 1;
        tick(1);
        spur = 0;
        tick(5);
        rst = 1;
        tick(2);
        rst = 0;
        tick(2);

        // reset with three ops outstanding, then a tie
        phase = 6;
        req0_x = rep4(32'h3f800000); req0_y = rep4(32'h3f800000); req0_vld = 1;
        tick(3);
        req0_vld = 0;
        rst = 1;
        tick(2);
        rst = 0;
        tick(1);
        phase = 8;
        req1_x = rep4(32'h40000000); req1_y = rep4(32'h40000000);
        req0_vld = 1; req1_vld = 1;
        tick(1);
        req0_vld = 0; req1_vld = 0;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
